ifu: RTL and testbench
======================

# ifu

Instruction fetch unit: owns the PC, issues word fetches to instruction memory over a request/grant/response handshake, buffers returned words with their addresses, and presents them in order to the if_id register that feeds the decoder. Handles redirects from execute (jump/branch) by flushing buffered and in-flight fetches, and honours the pipeline hold from control.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, fetch buffer entries; power of 2, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req_o  out  1  fetch request
- mem_addr_o  out  32  fetch word address (bits [1:0] always 00)
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  response data valid; in-order, ≥1 cycle after grant
- mem_rdata_i  in  32  response instruction word
- jump_en_i  in  1  redirect request from ex
- jump_addr_i  in  32  redirect target
- hold_i  in  1  downstream stall; head entry not consumed
- inst_valid_o  out  1  inst_o/inst_addr_o valid
- inst_o  out  32  instruction to if_id
- inst_addr_o  out  32  address of inst_o
- fetch_err_o  out  1  misaligned redirect target (see Configuration)

## Operation
- Fetch issued only when mem_req_o & mem_gnt_i in same cycle; pc advances by 4 on issue. mem_req_o may drop without grant.
- mem_req_o = (state==RUN) & !jump_en_i & (occupancy + outstanding < DEPTH), using registered counts only (a pop frees a slot next cycle).
- mem_addr_o = pc.
- Response with discard==0: push {pc_of_fetch, mem_rdata_i} into buffer; outstanding -1. Address FIFO of issued PCs, or pc minus outstanding*4, is implementer's choice; order must match.
- Response with discard>0: dropped; discard -1, outstanding -1.
- Output: head of buffer; inst_valid_o = !empty. Empty: inst_o = INST_NOP (32'h0000_0013), inst_addr_o = 0.
- Pop when inst_valid_o & !hold_i & !jump_en_i.
- Redirect (jump_en_i): buffer flushed, pc <= jump_addr_i, discard <= outstanding − mem_rvalid_i (counting the in-flight responses still owed), no request that cycle. Redirect overrides pop and push in same cycle.
- States: RST (one cycle after rst, no request) → RUN; RUN → ERR on misaligned redirect (macro only); ERR → RUN on aligned redirect.

## Timing
- Reset values: pc=RESET_PC, buffer empty, outstanding=0, discard=0, state=RST; mem_req_o=0, inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=0, fetch_err_o=0.
- First mem_req_o: second cycle after rst deasserts (RST state occupies the first).
- Grant cycle N, response N+k (k≥1): inst_valid_o earliest N+k+1 (buffer registered).
- Steady state at k=1, DEPTH=4, no hold: one instruction per cycle.
- Redirect cycle R: inst_valid_o=0 at R+1; first new request at R+1; first new instruction at R+3 (k=1).
- Hold: head held stable, fetch continues until full; full & hold: mem_req_o=0, no loss.
- Simultaneous push and pop on full buffer impossible (capacity rule); push and pop on non-empty allowed.
- rst mid-operation: all state cleared regardless of outstanding; responses after reset must be prevented by the memory (memory shares rst).

## Configuration
- IFU_MISALIGN_CHK_EN defined: redirect with jump_addr_i[1:0]!=0 flushes, enters ERR, fetch_err_o=1 (level) until next aligned redirect or rst; no requests in ERR; outstanding responses still drained via discard.
- Undefined: jump_addr_i[1:0] ignored (pc <= {jump_addr_i[31:2],2'b00}), ERR unreachable, fetch_err_o tied 0.

## Structure
- INST_NOP, RESET_PC default, and state encodings belong in the shared defines file.
- One sub-module: ifu_fifo (synchronous DEPTH×64 FIFO, push/pop/flush, count output); ifu holds pc, counters, FSM.

## Test plan
- Reset release, mem_gnt_i=1, k=1, rdata=addr^32'hA5A5_A5A5 -> requests 0,4,8,…; inst_valid_o from cycle 3, one per cycle, inst_addr_o 0,4,8 in order.
- hold_i=1 for 10 cycles -> buffer fills to 4, mem_req_o=0, inst_o stable at head; release -> 4 buffered then new words, no gap or duplicate.
- mem_gnt_i random 50%, k random 1–3 -> in-order delivery, occupancy+outstanding never >4.
- jump_en_i with 2 responses in flight, target 32'h100 -> both dropped, next inst_addr_o=32'h100, nothing from old stream.
- jump_en_i same cycle as pop and as mem_rvalid_i -> no pop, response dropped, pc=target.
- Macro on: jump_addr_i=32'h102 -> fetch_err_o=1, mem_req_o=0; jump to 32'h200 -> fetch_err_o=0, fetch 32'h200. Macro off: same stimulus fetches 32'h100.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro used by this slice: IFU_MISALIGN_CHK_EN.
package ifu_pkg;

   // Instruction presented to if_id while the fetch buffer is empty (addi x0,x0,0).
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;
   // Default first fetch address after reset (must be word aligned).
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   // Default fetch buffer depth (power of two, at least 2).
   localparam int          DEPTH_DEF    = 4;

   // ST_RST: one idle cycle after reset; ST_RUN: fetching; ST_ERR: parked
   // after a misaligned redirect until an aligned redirect arrives.
   typedef enum logic [1:0] {
      ST_RST = 2'd0,
      ST_RUN = 2'd1,
      ST_ERR = 2'd2
   } ifu_state_e;

   // One buffered fetch: the word together with the address it came from.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } fetch_entry_t;

   // Clear the byte offset of an address so it names a whole word.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_if.sv
// Bus bundle between the fetch unit, instruction memory, execute and if_id.
//
// Handshakes:
//   memory request : a fetch is issued only in a cycle where mem_req_o and
//                    mem_gnt_i are both high; mem_req_o may fall without a
//                    grant. Responses (mem_rvalid_i) return in issue order at
//                    least one cycle after their grant and cannot be stalled.
//   instruction out: inst_o/inst_addr_o are valid while inst_valid_o is high;
//                    the head is consumed in a cycle with inst_valid_o high,
//                    hold_i low and jump_en_i low, otherwise it stays stable.
//   redirect       : jump_en_i is a single-cycle strobe with jump_addr_i.
interface ifu_if;

   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        fetch_err_o;

   // Fetch unit side.
   modport master (
      output mem_req_o, mem_addr_o,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  jump_en_i, jump_addr_i, hold_i,
      output inst_valid_o, inst_o, inst_addr_o, fetch_err_o
   );

   // Environment side: memory, execute and if_id.
   modport slave (
      input  mem_req_o, mem_addr_o,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output jump_en_i, jump_addr_i, hold_i,
      input  inst_valid_o, inst_o, inst_addr_o, fetch_err_o
   );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous fetch buffer: DEPTH entries of {address, instruction}, with
// push, pop and a flush that empties it in one cycle. The caller never
// pushes when full or pops when empty.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wdata,
   output fetch_entry_t rdata,
   output logic [CW-1:0] count,
   output logic         empty
);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; flush discards everything like a reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues word fetches, buffers returned
// words with their addresses and presents them in order to if_id. Redirects
// flush the buffer and mark in-flight responses for discard.
// Optional feature macro: IFU_MISALIGN_CHK_EN (misaligned redirect -> ERR
// state with fetch_err_o raised); when undefined the target is word aligned.
module ifu
   import ifu_pkg::*;
#(
   parameter  logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter  int          DEPTH    = DEPTH_DEF,
   localparam int          CW       = $clog2(DEPTH) + 1
) (
   input  logic       clk,
   input  logic       rst,
   ifu_if.master      bus,
   output ifu_state_e dbg_state
);

   ifu_state_e   state;
   ifu_state_e   state_next;
   logic [31:0]  pc;
   logic [CW-1:0] outstanding;   // granted fetches whose response is still owed
   logic [CW-1:0] discard;       // oldest owed responses that belong to a flushed stream

   logic          issue;
   logic          jump;
   logic          misaligned;
   logic          room;
   logic          push;
   logic          pop;
   logic [CW:0]   fill;
   logic [31:0]   resp_addr;
   logic [CW-1:0] occ;
   logic          empty;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;

   assign jump  = bus.jump_en_i;
   assign issue = bus.mem_req_o & bus.mem_gnt_i;

`ifdef IFU_MISALIGN_CHK_EN
   assign misaligned = (bus.jump_addr_i[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Registered counts only, so a pop this cycle frees its slot next cycle.
   assign fill = {1'b0, occ} + {1'b0, outstanding};
   assign room = (fill < (CW+1)'(DEPTH));

   // Once discards are drained every owed response is from the current
   // stream, and the oldest of them was issued outstanding words before pc.
   assign resp_addr  = pc - (32'(outstanding) << 2);
   assign push_entry = '{addr: resp_addr, inst: bus.mem_rdata_i};

   // A redirect overrides both push and pop in its cycle.
   assign push = bus.mem_rvalid_i & (discard == '0) & ~jump;
   assign pop  = ~empty & ~bus.hold_i & ~jump;

   ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (jump),
      .wdata (push_entry),
      .rdata (head),
      .count (occ),
      .empty (empty)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RST;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and fetch request.
   always_comb begin
      state_next    = state;
      bus.mem_req_o = 1'b0;
      case (state)
         ST_RST:  state_next = ST_RUN;
         ST_RUN:  bus.mem_req_o = ~jump & room;
         ST_ERR:  state_next = ST_ERR;
         default: state_next = ST_RST;
      endcase
      if (jump) begin
         state_next = misaligned ? ST_ERR : ST_RUN;
      end
   end

   // PC, outstanding and discard counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else if (jump) begin
         // No request goes out on a redirect, so only a response can retire.
         pc          <= word_align(bus.jump_addr_i);
         outstanding <= outstanding - CW'(bus.mem_rvalid_i);
         discard     <= outstanding - CW'(bus.mem_rvalid_i);
      end else begin
         if (issue) begin
            pc <= pc + 32'd4;
         end
         outstanding <= outstanding + CW'(issue) - CW'(bus.mem_rvalid_i);
         if (bus.mem_rvalid_i && (discard != '0)) begin
            discard <= discard - CW'(1);
         end
      end
   end

   assign bus.mem_addr_o   = pc;
   assign bus.inst_valid_o = ~empty;
   assign bus.inst_o       = empty ? INST_NOP : head.inst;
   assign bus.inst_addr_o  = empty ? 32'h0 : head.addr;

`ifdef IFU_MISALIGN_CHK_EN
   assign bus.fetch_err_o  = (state == ST_ERR);
`else
   assign bus.fetch_err_o  = 1'b0;
`endif

   assign dbg_state = state;

endmodule

// File: tb/tb_ifu.sv
// Directed testbench for ifu: a memory responder with configurable grant and
// latency, an expected-instruction queue, and per-cycle checks of validity,
// capacity and fetch addresses. Honours IFU_MISALIGN_CHK_EN like the design.
module tb_ifu;
   import ifu_pkg::*;

   localparam int          DEPTH = 4;
   localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   ifu_state_e dbg_state;

   always #5 clk = ~clk;

   ifu_if bus ();

   ifu #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          last_due = 0;
   logic [63:0] exp_q[$];
   int          m_occ = 0, m_inflight = 0, m_disc = 0, pops = 0;
   logic [31:0] exp_fetch_pc = 32'h0;

   // stimulus knobs
   bit          gnt_rand = 1'b0, hold_rand = 1'b0, hold = 1'b0, jmp = 1'b0;
   int          k_lo = 1, k_hi = 1;
   logic [31:0] jmp_addr = 32'h0;

   // values observed in the most recent step
   logic        o_req, o_valid, o_err, o_rv;
   logic [31:0] o_addr, o_inst, o_inst_addr;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int ncyc);
      rst              = 1'b1;
      jmp              = 1'b0;
      hold             = 1'b0;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = 32'h0;
      bus.jump_en_i    = 1'b0;
      bus.jump_addr_i  = 32'h0;
      bus.hold_i       = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
      chk("rst_req",   bus.mem_req_o, 0);
      chk("rst_valid", bus.inst_valid_o, 0);
      chk("rst_inst",  bus.inst_o, INST_NOP);
      chk("rst_addr",  bus.inst_addr_o, 0);
      chk("rst_err",   bus.fetch_err_o, 0);
      chk("rst_state", dbg_state, ST_RST);
      // The memory shares rst, so anything it still owed is dropped.
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      last_due     = cyc;
      m_occ        = 0;
      m_inflight   = 0;
      m_disc       = 0;
      exp_fetch_pc = 32'h0;
      rst          = 1'b0;
   endtask

   // One clock cycle: drive inputs, sample, check, update memory and model.
   task automatic step();
      logic        rv, gnt, h, issue, pop;
      logic [31:0] a;
      logic [63:0] e;
      int          due;
      a   = 32'h0;
      gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      h   = hold_rand ? ($urandom_range(0, 3) == 0) : hold;
      rv  = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
      bus.mem_gnt_i    = gnt;
      bus.mem_rvalid_i = rv;
      bus.mem_rdata_i  = rv ? (pend_addr[0] ^ KEY) : 32'h0;
      bus.hold_i       = h;
      bus.jump_en_i    = jmp;
      bus.jump_addr_i  = jmp_addr;
      #2;
      o_req       = bus.mem_req_o;
      o_addr      = bus.mem_addr_o;
      o_valid     = bus.inst_valid_o;
      o_inst      = bus.inst_o;
      o_inst_addr = bus.inst_addr_o;
      o_err       = bus.fetch_err_o;
      o_rv        = rv;

      chk("valid", o_valid, m_occ != 0);
      if (!o_valid) begin
         chk("nop_inst", o_inst, INST_NOP);
         chk("nop_addr", o_inst_addr, 0);
      end
      if (o_req) begin
         chk("req_gate", {jmp, (m_occ + m_inflight) < DEPTH}, 2'b01);
      end
      issue = o_req & gnt;
      if (issue) begin
         chk("fetch_addr", o_addr, exp_fetch_pc);
         exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      pop = o_valid & !h & !jmp;
      if (pop) begin
         chk("sb_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("inst_addr", o_inst_addr, e[63:32]);
            chk("inst", o_inst, e[31:0]);
         end
         pops++;
      end

      // memory responder
      if (rv) begin
         a = pend_addr.pop_front();
         void'(pend_due.pop_front());
      end
      if (issue) begin
         due = cyc + $urandom_range(k_lo, k_hi);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_addr.push_back(o_addr);
         pend_due.push_back(due);
      end

      // expected buffer contents
      if (jmp) begin
         exp_q.delete();
         m_occ        = 0;
         m_disc       = m_inflight - int'(rv);
         m_inflight   = m_inflight - int'(rv);
         exp_fetch_pc = {jmp_addr[31:2], 2'b00};
      end else begin
         if (rv) begin
            if (m_disc > 0) m_disc--;
            else begin
               m_occ++;
               exp_q.push_back({a, a ^ KEY});
            end
         end
         if (pop) m_occ--;
         m_inflight = m_inflight + int'(issue) - int'(rv);
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      logic [31:0] head;
      int          i;
      @(posedge clk);
      #1;

      // Reset release, back-to-back fetch at k=1.
      do_reset(2);
      step(); chk("first_cycle_req", o_req, 0);
      step(); chk("first_req", o_req, 1); chk("first_req_addr", o_addr, 32'h0);
      step(); chk("lat_valid0", o_valid, 0);
      step(); chk("lat_valid1", o_valid, 1); chk("lat_first_addr", o_inst_addr, 32'h0);
      pops = 0;
      repeat (12) step();
      chk("throughput", pops, 12);

      // Hold until full, then release with no gap.
      hold = 1'b1;
      step();
      head = o_inst;
      repeat (9) begin
         step();
         chk("hold_stable", o_inst, head);
      end
      chk("hold_full_req", o_req, 0);
      hold = 1'b0;
      pops = 0;
      repeat (8) step();
      chk("hold_release_tp", pops, 8);

      // Redirect in a cycle that also pops and receives a response.
      step();
      jmp = 1'b1; jmp_addr = 32'h0000_0180;
      step();
      jmp = 1'b0;
      chk("jump_ctx", {o_valid, o_rv}, 2'b11);
      step(); chk("redir_valid_r1", o_valid, 0); chk("redir_req_r1", o_req, 1);
      chk("redir_addr_r1", o_addr, 32'h0000_0180);
      step(); chk("redir_valid_r2", o_valid, 0);
      step(); chk("redir_valid_r3", o_valid, 1); chk("redir_inst_r3", o_inst_addr, 32'h0000_0180);

      // Random grant, latency 1..3, random hold.
      gnt_rand = 1'b1; hold_rand = 1'b1; k_lo = 1; k_hi = 3;
      repeat (300) step();
      gnt_rand = 1'b0; hold_rand = 1'b0; k_lo = 1; k_hi = 1;
      repeat (10) step();

      // Redirect with two responses in flight.
      k_lo = 3; k_hi = 3;
      do_reset(2);
      i = 0;
      while (m_inflight != 2 && i < 20) begin
         step();
         i++;
      end
      chk("inflight2_reached", m_inflight, 2);
      jmp = 1'b1; jmp_addr = 32'h0000_0100;
      step();
      jmp = 1'b0; k_lo = 1; k_hi = 1;
      i = 0;
      do begin
         step();
         i++;
      end while (!o_valid && i < 12);
      chk("jump2_valid", o_valid, 1);
      chk("jump2_first_addr", o_inst_addr, 32'h0000_0100);
      repeat (6) step();

      // Misaligned redirect target.
      jmp = 1'b1; jmp_addr = 32'h0000_0102;
      step();
      jmp = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
      repeat (4) begin
         step();
         chk("err_level", o_err, 1);
         chk("err_no_req", o_req, 0);
      end
      chk("err_state", dbg_state, ST_ERR);
      jmp = 1'b1; jmp_addr = 32'h0000_0200;
      step();
      jmp = 1'b0;
      chk("err_on_clear_cycle", o_err, 1);
      step();
      chk("err_cleared", o_err, 0);
      chk("refetch_req", o_req, 1);
      chk("refetch_addr", o_addr, 32'h0000_0200);
`else
      step();
      chk("no_err", o_err, 0);
      chk("mis_req", o_req, 1);
      chk("mis_addr", o_addr, 32'h0000_0100);
`endif
      repeat (8) step();

      // Reset in the middle of random traffic.
      gnt_rand = 1'b1; k_lo = 1; k_hi = 3;
      repeat (20) step();
      gnt_rand = 1'b0; k_lo = 1; k_hi = 1;
      do_reset(2);
      step(); chk("mid_rst_idle", o_req, 0);
      step(); chk("mid_rst_req", o_req, 1); chk("mid_rst_addr", o_addr, 32'h0);
      repeat (8) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
